uart_pkt_comm: RTL and testbench
================================

Name: uart_pkt_comm

Overview:
Parametrised command/response framer between a byte-level UART transceiver and the flight-control host logic. On the receive side it assembles a frame of one opcode byte, DATA_BYTES parameter bytes and an optional checksum byte, and presents the frame atomically to the host. On the transmit side it serialises a RESP_BYTES-wide response through the UART transmitter. It adds an inter-byte timeout, checksum checking and overrun reporting.

Parameters:
DATA_BYTES, 2, number of parameter bytes per frame (1..4); data width = 8*DATA_BYTES
RESP_BYTES, 1, number of response bytes per transmission (1..4)
MSB_FIRST, 1, 1 = first received/sent parameter byte is the most significant; 0 = least significant first
CKSUM_EN, 0, 1 = a trailing checksum byte follows the parameter bytes
TIMEOUT_CYC, 1000000, idle clk cycles allowed between bytes of one frame; 0 disables the timeout

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_byte  input  8  received byte from the UART; valid when rx_vld=1
rx_vld  input  1  one-cycle pulse: new rx_byte available
tx_byte  output  8  byte to the UART transmitter
tx_start  output  1  one-cycle pulse: transmit tx_byte
tx_done  input  1  one-cycle pulse: UART finished the current byte
cmd  output  8  opcode of the last accepted frame
data  output  8*DATA_BYTES  parameter of the last accepted frame
cmd_rdy  output  1  a new frame is available
clr_cmd_rdy  input  1  host has consumed the frame
resp  input  8*RESP_BYTES  response word
send_resp  input  1  request to transmit resp
resp_sent  output  1  one-cycle pulse: last response byte done
tx_busy  output  1  response transmission in progress
cksum_err  output  1  one-cycle pulse: frame dropped on checksum mismatch
timeout_err  output  1  one-cycle pulse: partial frame dropped on timeout
overrun  output  1  one-cycle pulse: frame accepted while cmd_rdy already 1

Behaviour:
- Reset values are 0 for every output: cmd, data, cmd_rdy, tx_byte, tx_start, resp_sent, tx_busy and the error pulses. Both FSMs reset to IDLE, and the counters reset to 0.
- RX FSM states are R_IDLE, R_DATA and R_CKSUM. It advances only on rx_vld.
- R_IDLE: on rx_vld, store rx_byte in the opcode staging register, clear byte_cnt and the running sum, then go to R_DATA.
- R_DATA: on each rx_vld, store the byte in the staging slot given by byte_cnt and MSB_FIRST, then increment byte_cnt. After DATA_BYTES bytes, go to R_CKSUM if CKSUM_EN=1, otherwise complete the frame.
- R_CKSUM: on rx_vld, if rx_byte == ~(sum[7:0]) of the opcode and all parameter bytes, complete the frame. Otherwise pulse cksum_err. In both cases return to R_IDLE.
- Frame completion happens on the clock edge that accepts the final byte. On that edge, cmd, data and cmd_rdy=1 update together and are visible on the next cycle. cmd and data hold their values until the next completed frame. Partial or bad frames never alter cmd or data.
- cmd_rdy is an SR flop. Completion sets it; clr_cmd_rdy clears it. If both occur in the same cycle, set wins.
- If a frame completes while cmd_rdy=1: cmd and data are overwritten, cmd_rdy stays 1, and overrun pulses for 1 cycle.
- Timeout: a counter runs while the RX FSM is not in R_IDLE. It resets on every rx_vld.
  - When the counter reaches TIMEOUT_CYC: the FSM returns to R_IDLE, staging is discarded, and timeout_err pulses.
  - If rx_vld arrives in the expiry cycle, the byte wins and no timeout occurs.
- TX FSM states are T_IDLE, T_SEND and T_WAIT.
- T_IDLE: on send_resp, latch resp, set tx_busy=1, clear tx_idx, and go to T_SEND.
- T_SEND: drive tx_byte from the latched slot tx_idx (honouring MSB_FIRST), pulse tx_start for 1 cycle, then go to T_WAIT.
- T_WAIT: on tx_done, increment tx_idx. If bytes remain, go to T_SEND. After the last byte, pulse resp_sent, clear tx_busy and go to T_IDLE.
- send_resp is ignored while tx_busy=1. A new send_resp is accepted in the cycle after resp_sent.
- The RX and TX paths are independent. Asserting rst_n low mid-frame or mid-transmission aborts both immediately to reset values.

Test Plan:
- DATA_BYTES=2, MSB_FIRST=1, CKSUM_EN=1; send 0xA5, 0x12, 0x34, 0x14 -> cmd=0xA5, data=0x1234, cmd_rdy=1 one cycle after the last rx_vld; no error pulses.
- Same configuration; send 0xA5, 0x12, 0x34, 0x15 -> cksum_err pulses once; cmd_rdy and data unchanged.
- MSB_FIRST=0, CKSUM_EN=0; send 0x07, 0xCD, 0xAB -> data=0xABCD. Without clr_cmd_rdy, send 0x08, 0x01, 0x00 -> cmd=0x08, data=0x0001, overrun pulses, cmd_rdy remains 1.
- TIMEOUT_CYC=1000; send 0x33 then wait 1000 cycles -> timeout_err pulses. Then send 0x44, 0x55, 0x66 -> cmd=0x44, data=0x5566.
- RESP_BYTES=2, MSB_FIRST=1, resp=0xBEEF, send_resp pulsed -> tx_start with tx_byte=0xBE, and after tx_done, tx_start with tx_byte=0xEF. After the second tx_done, resp_sent pulses and tx_busy falls. A send_resp pulsed mid-transfer is ignored.
- Assert clr_cmd_rdy in the same cycle as a frame completes -> cmd_rdy=1. Assert rst_n low mid-frame -> all outputs 0; the next full frame decodes correctly.

Source files
------------

// File: rtl/uart_pkt_comm_if.sv
// Signal bundle between the packet framer (slave) and the host/UART side that drives it (master).
interface uart_pkt_comm_if #(
  parameter int DATA_BYTES = 2,
  parameter int RESP_BYTES = 1
);
  logic [7:0]              rx_byte;
  logic                    rx_vld;
  logic [7:0]              tx_byte;
  logic                    tx_start;
  logic                    tx_done;
  logic [7:0]              cmd;
  logic [8*DATA_BYTES-1:0] data;
  logic                    cmd_rdy;
  logic                    clr_cmd_rdy;
  logic [8*RESP_BYTES-1:0] resp;
  logic                    send_resp;
  logic                    resp_sent;
  logic                    tx_busy;
  logic                    cksum_err;
  logic                    timeout_err;
  logic                    overrun;

  modport slave (
    input  rx_byte, rx_vld, tx_done, clr_cmd_rdy, resp, send_resp,
    output tx_byte, tx_start, cmd, data, cmd_rdy, resp_sent, tx_busy,
           cksum_err, timeout_err, overrun
  );

  modport master (
    output rx_byte, rx_vld, tx_done, clr_cmd_rdy, resp, send_resp,
    input  tx_byte, tx_start, cmd, data, cmd_rdy, resp_sent, tx_busy,
           cksum_err, timeout_err, overrun
  );
endinterface

// File: rtl/uart_pkt_comm.sv
// Command/response framer: assembles opcode + parameter (+ checksum) frames from UART bytes
// and serialises a multi-byte response back through the UART transmitter.
module uart_pkt_comm #(
  parameter int DATA_BYTES  = 2,
  parameter int RESP_BYTES  = 1,
  parameter int MSB_FIRST   = 1,
  parameter int CKSUM_EN    = 0,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_pkt_comm_if.slave   pkt_if
);
  localparam int DW  = 8 * DATA_BYTES;
  localparam int RW  = 8 * RESP_BYTES;
  localparam int BW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TIW = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [1:0] R_IDLE = 2'd0, R_DATA = 2'd1, R_CKSUM = 2'd2;
  localparam logic [1:0] T_IDLE = 2'd0, T_SEND = 2'd1, T_WAIT = 2'd2;

  logic [1:0]     rx_st_q, rx_st_d;
  logic [BW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]     sum_q, sum_d;
  logic [7:0]     op_stage_q, op_stage_d;
  logic [DW-1:0]  data_stage_q, data_stage_d, new_stage;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [DW-1:0]  data_q, data_d;
  logic           cmd_rdy_q, cmd_rdy_d;
  logic           cksum_err_q, cksum_err_d;
  logic           timeout_err_q, timeout_err_d;
  logic           overrun_q, overrun_d;
  logic           complete;
  int             slot;

  logic [1:0]     tx_st_q, tx_st_d;
  logic [TIW-1:0] tx_idx_q, tx_idx_d;
  logic [RW-1:0]  resp_q, resp_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           tx_start_q, tx_start_d;
  logic           resp_sent_q, resp_sent_d;
  logic           tx_busy_q, tx_busy_d;
  int             tslot;

  always_comb begin
    rx_st_d       = rx_st_q;
    byte_cnt_d    = byte_cnt_q;
    sum_d         = sum_q;
    op_stage_d    = op_stage_q;
    data_stage_d  = data_stage_q;
    to_cnt_d      = to_cnt_q;
    cmd_d         = cmd_q;
    data_d        = data_q;
    cmd_rdy_d     = cmd_rdy_q & ~pkt_if.clr_cmd_rdy;
    cksum_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    overrun_d     = 1'b0;
    complete      = 1'b0;
    slot          = (MSB_FIRST != 0) ? (DATA_BYTES - 1 - int'(byte_cnt_q)) : int'(byte_cnt_q);
    new_stage     = data_stage_q;
    new_stage[slot*8 +: 8] = pkt_if.rx_byte;

    if (pkt_if.rx_vld) begin
      to_cnt_d = '0;
      case (rx_st_q)
        R_IDLE: begin
          op_stage_d = pkt_if.rx_byte;
          sum_d      = pkt_if.rx_byte;
          byte_cnt_d = '0;
          rx_st_d    = R_DATA;
        end
        R_DATA: begin
          data_stage_d = new_stage;
          sum_d        = sum_q + pkt_if.rx_byte;
          byte_cnt_d   = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BW'(DATA_BYTES - 1)) begin
            byte_cnt_d = '0;
            if (CKSUM_EN != 0) begin
              rx_st_d = R_CKSUM;
            end else begin
              complete = 1'b1;
              rx_st_d  = R_IDLE;
            end
          end
        end
        R_CKSUM: begin
          rx_st_d = R_IDLE;
          if (pkt_if.rx_byte == ~sum_q) complete = 1'b1;
          else                          cksum_err_d = 1'b1;
        end
        default: rx_st_d = R_IDLE;
      endcase
    end else if (rx_st_q != R_IDLE && TIMEOUT_CYC != 0) begin
      // A byte arriving in the expiry cycle takes the branch above, so it always wins.
      if (to_cnt_q == TO_LAST) begin
        rx_st_d       = R_IDLE;
        to_cnt_d      = '0;
        byte_cnt_d    = '0;
        timeout_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (complete) begin
      cmd_d     = op_stage_q;
      data_d    = data_stage_d;
      cmd_rdy_d = 1'b1;
      overrun_d = cmd_rdy_q;
    end
  end

  always_comb begin
    tx_st_d     = tx_st_q;
    tx_idx_d    = tx_idx_q;
    resp_d      = resp_q;
    tx_byte_d   = tx_byte_q;
    tx_start_d  = 1'b0;
    resp_sent_d = 1'b0;
    tx_busy_d   = tx_busy_q;
    tslot       = (MSB_FIRST != 0) ? (RESP_BYTES - 1 - int'(tx_idx_q)) : int'(tx_idx_q);
    case (tx_st_q)
      T_IDLE: begin
        if (pkt_if.send_resp) begin
          resp_d    = pkt_if.resp;
          tx_busy_d = 1'b1;
          tx_idx_d  = '0;
          tx_st_d   = T_SEND;
        end
      end
      T_SEND: begin
        tx_byte_d  = resp_q[tslot*8 +: 8];
        tx_start_d = 1'b1;
        tx_st_d    = T_WAIT;
      end
      T_WAIT: begin
        if (pkt_if.tx_done) begin
          if (tx_idx_q == TIW'(RESP_BYTES - 1)) begin
            tx_idx_d    = '0;
            resp_sent_d = 1'b1;
            tx_busy_d   = 1'b0;
            tx_st_d     = T_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
            tx_st_d  = T_SEND;
          end
        end
      end
      default: tx_st_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q       <= R_IDLE;
      byte_cnt_q    <= '0;
      sum_q         <= '0;
      op_stage_q    <= '0;
      data_stage_q  <= '0;
      to_cnt_q      <= '0;
      cmd_q         <= '0;
      data_q        <= '0;
      cmd_rdy_q     <= 1'b0;
      cksum_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      tx_st_q       <= T_IDLE;
      tx_idx_q      <= '0;
      resp_q        <= '0;
      tx_byte_q     <= '0;
      tx_start_q    <= 1'b0;
      resp_sent_q   <= 1'b0;
      tx_busy_q     <= 1'b0;
    end else begin
      rx_st_q       <= rx_st_d;
      byte_cnt_q    <= byte_cnt_d;
      sum_q         <= sum_d;
      op_stage_q    <= op_stage_d;
      data_stage_q  <= data_stage_d;
      to_cnt_q      <= to_cnt_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
      cmd_rdy_q     <= cmd_rdy_d;
      cksum_err_q   <= cksum_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      tx_st_q       <= tx_st_d;
      tx_idx_q      <= tx_idx_d;
      resp_q        <= resp_d;
      tx_byte_q     <= tx_byte_d;
      tx_start_q    <= tx_start_d;
      resp_sent_q   <= resp_sent_d;
      tx_busy_q     <= tx_busy_d;
    end
  end

  assign pkt_if.cmd         = cmd_q;
  assign pkt_if.data        = data_q;
  assign pkt_if.cmd_rdy     = cmd_rdy_q;
  assign pkt_if.cksum_err   = cksum_err_q;
  assign pkt_if.timeout_err = timeout_err_q;
  assign pkt_if.overrun     = overrun_q;
  assign pkt_if.tx_byte     = tx_byte_q;
  assign pkt_if.tx_start    = tx_start_q;
  assign pkt_if.resp_sent   = resp_sent_q;
  assign pkt_if.tx_busy     = tx_busy_q;
endmodule

// File: tb/tb_uart_pkt_comm.sv
// Directed bench for uart_pkt_comm: two framer configurations checked against frame/byte scoreboards.
module tb_uart_pkt_comm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_pkt_comm_if #(.DATA_BYTES(2), .RESP_BYTES(2)) a_if ();
  uart_pkt_comm_if #(.DATA_BYTES(2), .RESP_BYTES(2)) b_if ();

  // A: MSB first, checksum on, short timeout.  B: LSB first, no checksum, timeout disabled.
  uart_pkt_comm #(.DATA_BYTES(2), .RESP_BYTES(2), .MSB_FIRST(1), .CKSUM_EN(1), .TIMEOUT_CYC(1000))
    dut_a (.clk(clk), .rst_n(rst_n), .pkt_if(a_if.slave));
  uart_pkt_comm #(.DATA_BYTES(2), .RESP_BYTES(2), .MSB_FIRST(0), .CKSUM_EN(0), .TIMEOUT_CYC(0))
    dut_b (.clk(clk), .rst_n(rst_n), .pkt_if(b_if.slave));

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int a_to_n = 0, b_to_n = 0, a_txs_n = 0;

  logic [23:0] qa[$];
  logic [23:0] qb[$];
  logic [7:0]  qtx_a[$];
  logic [7:0]  qtx_b[$];

  always @(posedge clk) begin
    a_to_n  <= a_to_n + int'(a_if.timeout_err);
    b_to_n  <= b_to_n + int'(b_if.timeout_err);
    a_txs_n <= a_txs_n + int'(a_if.tx_start);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    a_if.rx_byte = b; a_if.rx_vld = 1'b1;
    step();
    a_if.rx_vld = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    b_if.rx_byte = b; b_if.rx_vld = 1'b1;
    step();
    b_if.rx_vld = 1'b0;
  endtask

  task automatic frame_chk(input bit use_b, input string tag);
    logic [23:0] e;
    int n;
    n = use_b ? qb.size() : qa.size();
    chk({tag, "_sb"}, 32'(n), 32'd1);
    e = '1;
    if (n > 0) e = use_b ? qb.pop_front() : qa.pop_front();
    chk({tag, "_rdy"},  use_b ? b_if.cmd_rdy : a_if.cmd_rdy, 32'd1);
    chk({tag, "_cmd"},  use_b ? b_if.cmd : a_if.cmd, 32'(e[23:16]));
    chk({tag, "_data"}, use_b ? b_if.data : a_if.data, 32'(e[15:0]));
    $display("frame %s: cmd=%02h data=%04h", tag,
             use_b ? b_if.cmd : a_if.cmd, use_b ? b_if.data : a_if.data);
  endtask

  task automatic tx_expect(input bit use_b, input string tag);
    logic [7:0] e;
    int n;
    n = 0;
    while ((use_b ? b_if.tx_start : a_if.tx_start) !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_start"}, use_b ? b_if.tx_start : a_if.tx_start, 32'd1);
    n = use_b ? qtx_b.size() : qtx_a.size();
    e = 8'hxx;
    if (n > 0) e = use_b ? qtx_b.pop_front() : qtx_a.pop_front();
    chk({tag, "_byte"}, use_b ? b_if.tx_byte : a_if.tx_byte, 32'(e));
    $display("tx %s: byte=%02h", tag, use_b ? b_if.tx_byte : a_if.tx_byte);
  endtask

  task automatic tx_done_pulse(input bit use_b);
    step();
    if (use_b) b_if.tx_done = 1'b1;
    else       a_if.tx_done = 1'b1;
    step();
    a_if.tx_done = 1'b0;
    b_if.tx_done = 1'b0;
  endtask

  initial begin
    a_if.rx_byte = '0; a_if.rx_vld = 1'b0; a_if.tx_done = 1'b0;
    a_if.clr_cmd_rdy = 1'b0; a_if.resp = '0; a_if.send_resp = 1'b0;
    b_if.rx_byte = '0; b_if.rx_vld = 1'b0; b_if.tx_done = 1'b0;
    b_if.clr_cmd_rdy = 1'b0; b_if.resp = '0; b_if.send_resp = 1'b0;
    repeat (3) step();
    chk("rst_a_outs", {a_if.cmd, a_if.data, a_if.cmd_rdy, a_if.tx_byte, a_if.tx_start,
                       a_if.resp_sent, a_if.tx_busy}, 32'd0);
    chk("rst_a_errs", {a_if.cksum_err, a_if.timeout_err, a_if.overrun}, 32'd0);
    chk("rst_b_outs", {b_if.cmd, b_if.data, b_if.cmd_rdy, b_if.tx_byte, b_if.tx_start,
                       b_if.resp_sent, b_if.tx_busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // Good checksum frame: ~(A5+12+34) = 14
    qa.push_back({8'hA5, 16'h1234});
    send_a(8'hA5); send_a(8'h12); send_a(8'h34);
    chk("a_rdy_before_last", a_if.cmd_rdy, 32'd0);
    send_a(8'h14);
    frame_chk(1'b0, "a_good");
    chk("a_good_errs", {a_if.cksum_err, a_if.timeout_err, a_if.overrun}, 32'd0);

    // Bad checksum: frame dropped, outputs untouched
    send_a(8'hA5); send_a(8'h12); send_a(8'h34); send_a(8'h15);
    chk("a_ck_err", a_if.cksum_err, 32'd1);
    chk("a_ck_hold", {a_if.cmd_rdy, a_if.cmd, a_if.data}, {7'd0, 1'b1, 8'hA5, 16'h1234});
    chk("a_ck_no_ovr", a_if.overrun, 32'd0);
    step();
    chk("a_ck_err_end", a_if.cksum_err, 32'd0);
    a_if.clr_cmd_rdy = 1'b1; step(); a_if.clr_cmd_rdy = 1'b0;
    chk("a_clr", a_if.cmd_rdy, 32'd0);

    // Timeout: 1000 idle cycles after a byte
    send_a(8'h33);
    repeat (999) step();
    chk("a_to_early", a_if.timeout_err, 32'd0);
    step();
    chk("a_to_pulse", a_if.timeout_err, 32'd1);
    chk("a_to_hold", {a_if.cmd_rdy, a_if.cmd}, {23'd0, 1'b0, 8'hA5});
    step();
    chk("a_to_end", a_if.timeout_err, 32'd0);

    // Byte arriving in the expiry cycle wins; ~(44+55+66) = 00
    qa.push_back({8'h44, 16'h5566});
    send_a(8'h44);
    repeat (999) step();
    send_a(8'h55); send_a(8'h66); send_a(8'h00);
    frame_chk(1'b0, "a_after_to");
    step();
    chk("a_to_count", 32'(a_to_n), 32'd1);

    // Clear and completion in the same cycle: set wins
    a_if.clr_cmd_rdy = 1'b1; step(); a_if.clr_cmd_rdy = 1'b0;
    qa.push_back({8'h01, 16'h0203});
    send_a(8'h01); send_a(8'h02); send_a(8'h03);
    a_if.clr_cmd_rdy = 1'b1;
    send_a(8'hF9);
    a_if.clr_cmd_rdy = 1'b0;
    frame_chk(1'b0, "a_clr_set");
    chk("a_clr_set_ovr", a_if.overrun, 32'd0);

    // Response, MSB first; a send_resp mid-transfer is ignored
    a_if.resp = 16'hBEEF; a_if.send_resp = 1'b1;
    qtx_a.push_back(8'hBE); qtx_a.push_back(8'hEF);
    step();
    a_if.send_resp = 1'b0;
    chk("a_busy", a_if.tx_busy, 32'd1);
    tx_expect(1'b0, "a_tx0");
    a_if.resp = 16'h1234; a_if.send_resp = 1'b1; step(); a_if.send_resp = 1'b0;
    tx_done_pulse(1'b0);
    tx_expect(1'b0, "a_tx1");
    tx_done_pulse(1'b0);
    chk("a_resp_sent", {a_if.resp_sent, a_if.tx_busy}, 32'b10);
    step();
    chk("a_resp_sent_end", a_if.resp_sent, 32'd0);
    a_if.resp = 16'hCAFE; a_if.send_resp = 1'b1;
    qtx_a.push_back(8'hCA); qtx_a.push_back(8'hFE);
    step();
    a_if.send_resp = 1'b0;
    tx_expect(1'b0, "a_tx2");
    tx_done_pulse(1'b0);
    tx_expect(1'b0, "a_tx3");
    tx_done_pulse(1'b0);
    chk("a_resp_sent2", {a_if.resp_sent, a_if.tx_busy}, 32'b10);
    step();
    chk("a_tx_start_count", 32'(a_txs_n), 32'd4);

    // Asynchronous reset mid-frame and mid-transmission
    a_if.resp = 16'hBEEF; a_if.send_resp = 1'b1; step(); a_if.send_resp = 1'b0;
    send_a(8'h10); send_a(8'h20);
    chk("a_pre_rst_busy", a_if.tx_busy, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("a_mid_rst_outs", {a_if.cmd, a_if.data, a_if.cmd_rdy, a_if.tx_byte, a_if.tx_start,
                           a_if.resp_sent, a_if.tx_busy}, 32'd0);
    chk("a_mid_rst_errs", {a_if.cksum_err, a_if.timeout_err, a_if.overrun}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    qa.push_back({8'h21, 16'h5678});
    send_a(8'h21); send_a(8'h56); send_a(8'h78); send_a(8'h10);
    frame_chk(1'b0, "a_post_rst");
    chk("a_post_rst_errs", {a_if.cksum_err, a_if.overrun}, 32'd0);

    // B: LSB first, then overrun without clearing
    qb.push_back({8'h07, 16'hABCD});
    send_b(8'h07); send_b(8'hCD); send_b(8'hAB);
    frame_chk(1'b1, "b_lsb");
    chk("b_lsb_ovr", b_if.overrun, 32'd0);
    qb.push_back({8'h08, 16'h0001});
    send_b(8'h08); send_b(8'h01); send_b(8'h00);
    frame_chk(1'b1, "b_ovr_frame");
    chk("b_ovr_pulse", b_if.overrun, 32'd1);
    step();
    chk("b_ovr_end", {b_if.overrun, b_if.cmd_rdy}, 32'b01);
    b_if.clr_cmd_rdy = 1'b1; step(); b_if.clr_cmd_rdy = 1'b0;
    chk("b_clr", b_if.cmd_rdy, 32'd0);

    // B: timeout disabled, a long gap keeps the frame alive
    qb.push_back({8'h09, 16'h2211});
    send_b(8'h09);
    repeat (1200) step();
    send_b(8'h11); send_b(8'h22);
    frame_chk(1'b1, "b_no_to");
    step();
    chk("b_to_count", 32'(b_to_n), 32'd0);

    // B response, LSB first
    b_if.resp = 16'hBEEF; b_if.send_resp = 1'b1;
    qtx_b.push_back(8'hEF); qtx_b.push_back(8'hBE);
    step();
    b_if.send_resp = 1'b0;
    tx_expect(1'b1, "b_tx0");
    tx_done_pulse(1'b1);
    tx_expect(1'b1, "b_tx1");
    tx_done_pulse(1'b1);
    chk("b_resp_sent", {b_if.resp_sent, b_if.tx_busy}, 32'b10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
